uart_port_responder: RTL and testbench
======================================

// Module: uart_port_responder
// PURPOSE
// Peripheral-side responder for the CPU serial-port handshake. The CPU's memory controller drives
// the active-low strobes rdn/wrn and samples data_ready/tbre/tsre. This block answers those
// strobes and runs the serial link: 8N1, LSB first, with a TX holding register plus TX shifter,
// and an RX deserialiser feeding a small RX FIFO. It is the synthesizable stand-in for the
// board UART, used on FPGA builds and as the bus model in CPU testbenches.
// PARAMETERS
// CLKS_PER_BIT  16  CLK cycles per serial bit (>=4, even)
// RX_DEPTH      4   RX FIFO entries (power of 2, >=2)
// PORTS
// CLK          in   1  system clock, all logic on posedge
// RST          in   1  synchronous reset, active-high
// rdn          in   1  CPU read strobe, active-low
// wrn          in   1  CPU write strobe, active-low
// data_in      in   8  byte from CPU, valid while wrn=0
// data_out     out  8  byte to CPU
// data_oe      out  1  1 = drive data_out onto the shared bus
// data_ready   out  1  1 = RX FIFO non-empty
// tbre         out  1  1 = TX holding register empty
// tsre         out  1  1 = TX shifter idle (line idle)
// txd          out  1  serial out, idle high
// rxd          in   1  serial in, asynchronous
// rx_overrun   out  1  sticky: byte dropped because FIFO full
// framing_err  out  1  sticky: stop bit sampled 0
// BEHAVIOUR
// - Reset values: txd=1, tbre=1, tsre=1, data_ready=0, data_oe=0, data_out=0, flags=0.
//   FIFO is emptied and all FSMs return to IDLE. Reset mid-frame aborts; txd=1 on the next edge.
// - Strobes are registered once (wrn_q, rdn_q).
//   - Write event: wrn_q=0 && wrn=1. The block captures data_in from the previous cycle (held
//     in a register while wrn=0).
//   - Read event: rdn_q=0 && rdn=1.
// - Write event with tbre=1: load the holding register; tbre=0 on the next cycle.
//   Write event with tbre=0: the byte is discarded and no state changes.
// - TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE. Each state lasts CLKS_PER_BIT cycles.
//   - IDLE with the holding register full: move the byte into the shifter and enter START.
//     Next cycle tbre=1 and tsre=0.
//   - STOP ends: if the holding register is full, go directly to START (back-to-back frames,
//     no idle bit). Otherwise go to IDLE and set tsre=1.
//   - A write event arriving in the same cycle as the holding-register-to-shifter transfer is
//     rejected, because tbre is still 0.
// - Read path: while rdn=0, data_oe=1 and data_out=FIFO head (0x00 if empty). Else data_oe=0.
//   - On a read event with the FIFO non-empty: pop. data_ready updates on the next cycle.
//   - Read event on an empty FIFO: no effect.
// - RX: rxd passes through a 2-flop synchroniser (rx_s). RX FSM: IDLE -> START -> DATA -> STOP.
//   - IDLE: a falling edge on rx_s starts a frame. At CLKS_PER_BIT/2 the start bit is
//     re-sampled; if it is 1 (glitch), return to IDLE.
//   - Sample 8 data bits every CLKS_PER_BIT cycles, at bit centre, LSB first.
//   - Stop bit = 1: push the byte. If the FIFO is full, drop it and set rx_overrun.
//   - Stop bit = 0: no push, set framing_err. The FSM returns to IDLE and waits for rx_s=1
//     before detecting the next start.
//   - A push and a pop in the same cycle when full are legal: pop first, then push; count is
//     unchanged and no overrun.
// - Sticky flags clear only on RST.
// - Latency:
//   - First txd start-bit edge: 2 cycles after the write event.
//   - data_ready=1: 1 cycle after the stop-bit sample, i.e. about 9.5 bits after the start edge
//     plus 2 synchroniser cycles.
// TESTING
// 1 Reset: hold RST 3 cycles with rxd=0 -> all outputs at reset values. RX FSM stays IDLE
//   until rxd rises.
// 2 Write 0xA5 (wrn low 2 cycles) -> tbre=0 then tbre=1 and tsre=0. txd shows 0,1,0,1,0,0,1,0,1,1,
//   each bit 16 cycles. tsre=1 after the stop bit.
// 3 Write 0x11, then 0x22 while 0x11 shifts, then a third write while tbre=0 -> 0x11 and 0x22
//   are sent back-to-back. The third byte never appears on txd.
// 4 Drive frame 0x3C on rxd -> data_ready=1. Pulse rdn: data_oe=1, data_out=0x3C while low;
//   after release data_ready=0.
// 5 Send 5 frames 0x01..0x05 with no reads (RX_DEPTH=4) -> rx_overrun=1. Reads return
//   0x01..0x04, then the FIFO is empty.
// 6 Frame with stop bit 0 -> framing_err=1, no push. A start glitch of 4 cycles -> no frame;
//   the next valid frame 0x7E is received.

Source files
------------

// File: rtl/uart_port_responder.sv
// uart_port_responder: CPU strobe-handshake UART responder with TX holding register and RX FIFO
module uart_port_responder #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RX_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overrun,
  output logic       framing_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(RX_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_st, rx_st;
  logic wrn_q, rdn_q, rx_m, rx_s, rx_p;
  logic [7:0] din_q, hold, tx_sh, rx_sh;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] mem [RX_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic wr_ev, rd_ev, pop, push, full, stop_smp;
  assign wr_ev = !wrn_q && wrn;
  assign rd_ev = !rdn_q && rdn;
  assign full = count == FULL;
  assign pop = rd_ev && count != '0;
  assign stop_smp = rx_st == STOP && rx_cnt == LAST;
  assign push = stop_smp && rx_s && (!full || pop);
  assign data_ready = count != '0;
  assign data_oe = !rdn;
  assign data_out = (!rdn && data_ready) ? mem[rp] : 8'h00;
  // register strobes and hold the CPU byte while the write strobe is low
  always_ff @(posedge CLK) begin
    wrn_q <= RST ? 1'b1 : wrn;
    rdn_q <= RST ? 1'b1 : rdn;
    if (!wrn) din_q <= data_in;
  end
  // holding register and TX shifter; STOP chains straight into START when a byte is waiting
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_st <= IDLE;
      tbre <= 1'b1;
      tsre <= 1'b1;
      txd <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      hold <= '0;
      tx_sh <= '0;
    end else begin
      if (wr_ev && tbre) begin
        hold <= din_q;
        tbre <= 1'b0;
      end
      tx_cnt <= (tx_st == IDLE || tx_cnt == LAST) ? '0 : tx_cnt + 1'b1;
      case (tx_st)
        IDLE: if (!tbre) begin
          tx_sh <= hold;
          tbre <= 1'b1;
          tsre <= 1'b0;
          txd <= 1'b0;
          tx_st <= START;
        end
        START: if (tx_cnt == LAST) begin
          txd <= tx_sh[0];
          tx_bit <= '0;
          tx_st <= DATA;
        end
        DATA: if (tx_cnt == LAST) begin
          txd <= tx_bit == 3'd7 ? 1'b1 : tx_sh[1];
          tx_sh <= tx_sh >> 1;
          tx_bit <= tx_bit + 1'b1;
          if (tx_bit == 3'd7) tx_st <= STOP;
        end
        STOP: if (tx_cnt == LAST) begin
          if (!tbre) begin
            tx_sh <= hold;
            tbre <= 1'b1;
            txd <= 1'b0;
            tx_st <= START;
          end else begin
            tsre <= 1'b1;
            tx_st <= IDLE;
          end
        end
      endcase
    end
  end
  // synchroniser, RX deserialiser, FIFO pointers and sticky error flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      {rx_p, rx_s, rx_m} <= '0;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      rx_overrun <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      {rx_p, rx_s, rx_m} <= {rx_s, rx_m, rxd};
      rx_cnt <= (rx_st == IDLE || rx_cnt == LAST || (rx_st == START && rx_cnt == HALF)) ? '0 : rx_cnt + 1'b1;
      case (rx_st)
        IDLE: if (rx_p && !rx_s) rx_st <= START;
        START: if (rx_cnt == HALF) rx_st <= rx_s ? IDLE : DATA;
        DATA: if (rx_cnt == LAST) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st <= STOP;
        end
        STOP: if (rx_cnt == LAST) rx_st <= IDLE;
      endcase
      if (stop_smp && !rx_s) framing_err <= 1'b1;
      if (stop_smp && rx_s && full && !pop) rx_overrun <= 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // FIFO storage; a full-FIFO push overwrites the slot being popped this cycle
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= rx_sh;
  end
endmodule

// File: tb/tb_uart_port_responder.sv
// tb_uart_port_responder: scoreboard bench with byte-level serial reference model
module tb_uart_port_responder;
  localparam int C = 16;
  localparam int D = 4;
  logic CLK = 0, RST = 1, rdn = 1, wrn = 1, rxd = 0;
  logic [7:0] data_in = 0;
  logic [7:0] data_out;
  logic data_oe, data_ready, tbre, tsre, txd, rx_overrun, framing_err;
  int passed = 0, total = 0, cyc = 0, last_gap = 0, tx_frames = 0, st = -1, f0;
  logic [7:0] txq[$], rdq[$], mq[$];
  logic [7:0] mb;
  bit m_ovr = 0, m_fe = 0, oe_p = 0;

  uart_port_responder #(.CLKS_PER_BIT(C), .RX_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .rdn(rdn), .wrn(wrn), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .data_ready(data_ready),
    .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd),
    .rx_overrun(rx_overrun), .framing_err(framing_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  // TX monitor: decode frames from txd and compare against queued bytes
  initial forever begin
    @(posedge CLK); #1;
    if (!RST && txd === 1'b0) begin
      if (st >= 0) last_gap = cyc - st;
      st = cyc;
      repeat (C / 2) @(posedge CLK);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(posedge CLK);
        #1;
        mb[i] = txd;
      end
      repeat (C) @(posedge CLK);
      #1;
      chk("tx_stop", txd, 1);
      tx_frames++;
      chk("tx_queued", txq.size() > 0, 1);
      if (txq.size() > 0) chk("tx_byte", mb, txq.pop_front());
    end
  end

  // read monitor: compare the bus byte whenever the DUT starts driving it
  initial forever begin
    @(posedge CLK); #1;
    if (data_oe && !oe_p) begin
      chk("rd_queued", rdq.size() > 0, 1);
      if (rdq.size() > 0) chk("rd_data", data_out, rdq.pop_front());
    end
    oe_p = data_oe;
  end

  task automatic do_write(input logic [7:0] b, input bit accept, input bit idle_chk);
    @(negedge CLK);
    data_in = b;
    wrn = 0;
    repeat (2) @(negedge CLK);
    data_in = ~b;
    wrn = 1;
    if (accept) txq.push_back(b);
    @(posedge CLK); #1;
    if (idle_chk) begin
      chk("tbre_low", tbre, 0);
      chk("txd_idle", txd, 1);
    end
    @(posedge CLK); #1;
    if (idle_chk) begin
      chk("tbre_high", tbre, 1);
      chk("tsre_low", tsre, 0);
      chk("txd_start", txd, 0);
    end
  endtask

  task automatic wait_tbre();
    int n = 0;
    while (!tbre && n < 20 * C) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("tbre_wait", tbre, 1);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (!(tsre && tbre) && n < 40 * C) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("tx_idle_wait", tsre && tbre, 1);
    repeat (C) @(posedge CLK);
    #1;
  endtask

  task automatic do_read();
    @(negedge CLK);
    rdq.push_back(mq.size() != 0 ? mq.pop_front() : 8'h00);
    rdn = 0;
    repeat (2) @(negedge CLK);
    rdn = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rd_oe_off", data_oe, 0);
    chk("rd_ready", data_ready, mq.size() != 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      rxd = f[i];
      repeat (C - 1) @(negedge CLK);
    end
    @(negedge CLK);
    rxd = 1;
    repeat (4) @(negedge CLK);
    if (!stop) m_fe = 1;
    else if (mq.size() < D) mq.push_back(b);
    else m_ovr = 1;
    chk("rx_ready", data_ready, mq.size() != 0);
    chk("rx_overrun", rx_overrun, m_ovr);
    chk("rx_framing", framing_err, m_fe);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_tbre", tbre, 1);
    chk("rst_tsre", tsre, 1);
    chk("rst_ready", data_ready, 0);
    chk("rst_oe", data_oe, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovr", rx_overrun, 0);
    chk("rst_fe", framing_err, 0);
    @(negedge CLK);
    RST = 0;
    repeat (12 * C) @(negedge CLK);
    chk("rx_low_idle_fe", framing_err, 0);
    chk("rx_low_idle_rdy", data_ready, 0);
    rxd = 1;
    repeat (2 * C) @(negedge CLK);
    chk("rx_rise_fe", framing_err, 0);

    do_write(8'hA5, 1, 1);
    wait_tx_idle();

    f0 = tx_frames;
    do_write(8'h11, 1, 1);
    do_write(8'h22, 1, 0);
    do_write(8'h33, 0, 0);
    chk("tbre_full", tbre, 0);
    wait_tx_idle();
    chk("tx_b2b_frames", tx_frames - f0, 2);
    chk("tx_b2b_gap", last_gap, 10 * C);
    chk("tx_q_empty", txq.size(), 0);

    for (int i = 0; i < 4; i++) begin
      wait_tbre();
      do_write(8'($urandom), 1, 0);
    end
    wait_tx_idle();
    chk("tx_rand_q_empty", txq.size(), 0);

    send_rx(8'h3C, 1);
    do_read();

    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1);
    for (int i = 0; i < 5; i++) do_read();

    @(negedge CLK);
    rxd = 0;
    repeat (4) @(negedge CLK);
    rxd = 1;
    repeat (2 * C) @(negedge CLK);
    chk("glitch_ready", data_ready, 0);
    chk("glitch_fe", framing_err, 0);
    send_rx(8'h5A, 0);
    send_rx(8'h7E, 1);
    do_read();

    for (int i = 0; i < 10; i++) begin
      send_rx(8'($urandom), ($urandom % 8) != 0);
      if ($urandom % 2) do_read();
    end
    while (mq.size() != 0) do_read();
    do_read();
    repeat (4) @(posedge CLK);
    #1;
    chk("rd_q_empty", rdq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
